// File: rtl/sram_pkg.sv
// Shared types and constants for the SLC-3 on-chip SRAM responder.
package sram_pkg;

    localparam int DATA_W = 16;
    localparam int BUS_ADDR_W = 20;
    localparam logic [DATA_W-1:0] OUT_OF_RANGE_DATA = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        HOLD
    } sram_state_t;

    // Request attributes frozen at acceptance.
    typedef struct packed {
        logic              wr;
        logic              ub_n;
        logic              lb_n;
        logic              oor;
        logic [DATA_W-1:0] data;
    } sram_req_t;

endpackage

// File: rtl/sram_responder_spram.sv
// Single-port word array with per-byte write enables and a registered read.
module spram_bytewise #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          re_i,
    input  logic [1:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    localparam int HB = DW / 2;

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i[1]) begin
            mem_q[addr_i][DW-1:HB] <= wdata_i[DW-1:HB];
        end
        if (we_i[0]) begin
            mem_q[addr_i][HB-1:0] <= wdata_i[HB-1:0];
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// SLC-3 memory-bus responder: accepts CE/OE/WE requests, answers
// with a one-cycle R pulse after WAIT_STATES cycles.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  CE,
    input  logic                  OE,
    input  logic                  WE,
    input  logic                  UB,
    input  logic                  LB,
    input  logic [BUS_ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0]     Data_from_CPU,
    output logic [DATA_W-1:0]     Data_to_CPU,
    output logic                  R
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    sram_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    sram_req_t         cap_q, cap_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              r_q;

    logic              req;
    logic              mem_re;
    logic [1:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rd_word;
    logic              ack_rd;

    assign req = !CE && (!OE || !WE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        addr_d  = addr_q;
        mem_re  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    cap_d.wr   = !WE;
                    cap_d.ub_n = UB;
                    cap_d.lb_n = LB;
                    cap_d.oor  = (ADDR >> ADDR_W) != '0;
                    cap_d.data = Data_from_CPU;
                    addr_d     = ADDR[ADDR_W-1:0];
                    if (WS == 4'd0) begin
                        state_d = ACK;
                        mem_re  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ACK;
                        mem_re  = 1'b1;
                    end
                end
            end
            ACK: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // In IDLE only the zero-wait read uses the array, straight off the bus.
    assign mem_addr = (state_q == IDLE) ? ADDR[ADDR_W-1:0] : addr_q;

    always_comb begin
        mem_we = 2'b00;
        if (state_q == ACK && cap_q.wr && !cap_q.oor && !Reset) begin
            mem_we = {!cap_q.ub_n, !cap_q.lb_n};
        end
    end

    assign ack_rd  = (state_q == ACK) && !cap_q.wr;
    assign rd_word = cap_q.oor ? OUT_OF_RANGE_DATA : mem_rdata;
    assign dout_d  = ack_rd ? rd_word : dout_q;

    spram_bytewise #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_mem (
        .clk_i   (Clk),
        .re_i    (mem_re),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (cap_q.data),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            r_q     <= (state_d == ACK);
        end
    end

    assign Data_to_CPU = ack_rd ? rd_word : dout_q;
    assign R           = r_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder (WAIT_STATES=2 and 0 instances).
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, oe, we, ub, lb;
    logic [19:0] addr;
    logic [15:0] wd, rd;
    logic        r;
    logic        ce0, oe0, we0, ub0, lb0;
    logic [19:0] addr0;
    logic [15:0] wd0, rd0;
    logic        r0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model [int];

    always #5 clk = ~clk;

    sram_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut (
        .Clk(clk), .Reset(rst), .CE(ce), .OE(oe), .WE(we),
        .UB(ub), .LB(lb), .ADDR(addr), .Data_from_CPU(wd),
        .Data_to_CPU(rd), .R(r)
    );

    sram_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
        .Clk(clk), .Reset(rst), .CE(ce0), .OE(oe0), .WE(we0),
        .UB(ub0), .LB(lb0), .ADDR(addr0), .Data_from_CPU(wd0),
        .Data_to_CPU(rd0), .R(r0)
    );

    function automatic logic [15:0] ref_read(input logic [19:0] a);
        if (a >= 20'h400) return 16'h0000;
        return model[int'(a)];
    endfunction

    function automatic void ref_write(input logic [19:0] a, input logic [15:0] d,
                                      input bit ubn, input bit lbn);
        logic [15:0] w;
        if (a >= 20'h400) return;
        w = model.exists(int'(a)) ? model[int'(a)] : 16'hxxxx;
        if (!ubn) w[15:8] = d[15:8];
        if (!lbn) w[7:0]  = d[7:0];
        model[int'(a)] = w;
    endfunction

    task automatic idle_bus();
        ce = 1; oe = 1; we = 1; ub = 1; lb = 1; addr = '0; wd = '0;
    endtask

    // One access on the WAIT_STATES=2 instance; returns R latency,
    // read data at R, and any R pulses seen while the request is held.
    task automatic access(input bit is_wr, input bit both, input logic [19:0] a,
                          input logic [15:0] d, input bit ubn, input bit lbn,
                          output int lat, output logic [15:0] data, output int extra);
        @(posedge clk); #1;
        ce = 0; oe = (is_wr && !both); we = !is_wr;
        ub = ubn; lb = lbn; addr = a; wd = d;
        lat = -1; data = 'x; extra = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                addr = 20'($urandom); wd = 16'($urandom);
            end
            if (r) begin
                lat = n; data = rd; break;
            end
        end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (r) extra++;
        end
        idle_bus();
        @(posedge clk); #1;
        if (is_wr) ref_write(a, d, ubn, lbn);
    endtask

    task automatic test_reset();
        rst = 1; idle_bus();
        ce0 = 1; oe0 = 1; we0 = 1; ub0 = 1; lb0 = 1; addr0 = '0; wd0 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (r !== 1'b0) begin n_fail++; $display("FAIL reset_r: got %b want 0", r); end
        n_checks++;
        if (rd !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", rd); end
        n_checks++;
        if (r0 !== 1'b0 || rd0 !== 16'h0000) begin
            n_fail++; $display("FAIL reset_ws0: got r=%b d=%h want 0/0000", r0, rd0);
        end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, ex; logic [15:0] d;
        access(1, 0, 20'h10, 16'hBEEF, 0, 0, lat, d, ex);
        n_checks++;
        if (lat !== 3 || ex !== 0) begin
            n_fail++; $display("FAIL basic_wr_lat: got lat=%0d extra=%0d want 3/0", lat, ex);
        end
        access(0, 0, 20'h10, 16'h0000, 0, 0, lat, d, ex);
        n_checks++;
        if (lat !== 3 || ex !== 0) begin
            n_fail++; $display("FAIL basic_rd_lat: got lat=%0d extra=%0d want 3/0", lat, ex);
        end
        n_checks++;
        if (d !== 16'hBEEF) begin n_fail++; $display("FAIL basic_rd_data: got %h want BEEF", d); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL data_hold: got %h want BEEF", rd); end
    endtask

    task automatic test_byte_lanes();
        int lat, ex; logic [15:0] d;
        access(1, 0, 20'h20, 16'h1234, 0, 0, lat, d, ex);
        access(1, 1, 20'h20, 16'hAB00, 0, 1, lat, d, ex);
        access(0, 0, 20'h20, 16'h0000, 0, 0, lat, d, ex);
        n_checks++;
        if (d !== 16'hAB34) begin n_fail++; $display("FAIL lane_upper: got %h want AB34", d); end
        access(1, 0, 20'h20, 16'hFFCD, 1, 0, lat, d, ex);
        access(1, 0, 20'h20, 16'h9999, 1, 1, lat, d, ex);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL lane_none_r: got lat=%0d want 3", lat); end
        access(0, 0, 20'h20, 16'h0000, 1, 1, lat, d, ex);
        n_checks++;
        if (d !== 16'hABCD) begin n_fail++; $display("FAIL lane_lower: got %h want ABCD", d); end
    endtask

    task automatic test_abort();
        int lat, ex, pulses; logic [15:0] d;
        access(1, 0, 20'h30, 16'h1111, 0, 0, lat, d, ex);
        access(0, 0, 20'h10, 16'h0000, 0, 0, lat, d, ex);
        @(posedge clk); #1;
        ce = 0; oe = 1; we = 0; ub = 0; lb = 0; addr = 20'h30; wd = 16'h5555;
        @(posedge clk); #1;
        ce = 1;
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (r) pulses++;
        end
        idle_bus();
        n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL abort_r: got %0d pulses want 0", pulses); end
        n_checks++;
        if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL abort_data: got %h want BEEF", rd); end
        access(0, 0, 20'h30, 16'h0000, 0, 0, lat, d, ex);
        n_checks++;
        if (d !== 16'h1111) begin n_fail++; $display("FAIL abort_mem: got %h want 1111", d); end
    endtask

    task automatic test_out_of_range();
        int lat, ex; logic [15:0] d;
        access(1, 0, 20'h00000, 16'hC0DE, 0, 0, lat, d, ex);
        access(1, 0, 20'h00400, 16'h7777, 0, 0, lat, d, ex);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL oor_wr_r: got lat=%0d want 3", lat); end
        access(0, 0, 20'h00400, 16'h0000, 0, 0, lat, d, ex);
        n_checks++;
        if (lat !== 3 || d !== 16'h0000) begin
            n_fail++; $display("FAIL oor_rd: got lat=%0d d=%h want 3/0000", lat, d);
        end
        access(0, 0, 20'h00000, 16'h0000, 0, 0, lat, d, ex);
        n_checks++;
        if (d !== 16'hC0DE) begin n_fail++; $display("FAIL oor_alias: got %h want C0DE", d); end
    endtask

    task automatic test_reset_mid();
        int lat, ex, pulses; logic [15:0] d;
        access(1, 0, 20'h40, 16'h4444, 0, 0, lat, d, ex);
        @(posedge clk); #1;
        ce = 0; oe = 1; we = 0; ub = 0; lb = 0; addr = 20'h40; wd = 16'h9999;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        idle_bus();
        n_checks++;
        if (r !== 1'b0) begin n_fail++; $display("FAIL rst_mid_r: got %b want 0", r); end
        rst = 0;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (r) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL rst_mid_pulse: got %0d want 0", pulses); end
        access(0, 0, 20'h40, 16'h0000, 0, 0, lat, d, ex);
        n_checks++;
        if (lat !== 3 || d !== 16'h4444) begin
            n_fail++; $display("FAIL rst_mid_mem: got lat=%0d d=%h want 3/4444", lat, d);
        end
    endtask

    task automatic test_ws0();
        int first, pulses; logic [15:0] d;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            ce0 = 0; oe0 = (k == 0); we0 = (k != 0); ub0 = 0; lb0 = 0;
            addr0 = 20'h55; wd0 = 16'hA5C3;
            first = -1; pulses = 0; d = 'x;
            for (int n = 1; n <= 5; n++) begin
                @(posedge clk); #1;
                addr0 = 20'($urandom); wd0 = 16'($urandom);
                if (r0) begin
                    pulses++;
                    if (first < 0) begin first = n; d = rd0; end
                end
            end
            ce0 = 1; oe0 = 1; we0 = 1;
            @(posedge clk); #1;
            n_checks++;
            if (first !== 1 || pulses !== 1) begin
                n_fail++; $display("FAIL ws0_pulse%0d: got first=%0d n=%0d want 1/1", k, first, pulses);
            end
            if (k == 1) begin
                n_checks++;
                if (d !== 16'hA5C3) begin n_fail++; $display("FAIL ws0_data: got %h want A5C3", d); end
            end
        end
    endtask

    task automatic test_random();
        int lat, ex; logic [15:0] d, exp_d;
        logic [19:0] a;
        bit wr, ubn, lbn;
        for (int i = 0; i < 8; i++) begin
            access(1, 0, 20'(20'h100 + i * 3), 16'($urandom), 0, 0, lat, d, ex);
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) a = 20'h400 | 20'($urandom_range(0, 20'hFFBFF));
            else a = 20'(20'h100 + $urandom_range(0, 7) * 3);
            wr = 1'($urandom); ubn = 1'($urandom); lbn = 1'($urandom);
            exp_d = ref_read(a);
            access(wr, 1'($urandom), a, 16'($urandom), ubn, lbn, lat, d, ex);
            n_checks++;
            if (lat !== 3 || ex !== 0) begin
                n_fail++; $display("FAIL rnd_lat[%0d]: got lat=%0d extra=%0d want 3/0", i, lat, ex);
            end
            if (!wr) begin
                n_checks++;
                if (d !== exp_d) begin
                    n_fail++; $display("FAIL rnd_rd[%0d] a=%h: got %h want %h", i, a, d, exp_d);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_abort();
        test_out_of_range();
        test_reset_mid();
        test_ws0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

On-chip memory responder for the SLC-3 memory bus. It answers the CPU-side SRAM control signals (CE, OE, WE, UB, LB, ADDR, Data_from_CPU) with read data and a one-cycle ready pulse `R` after a fixed number of wait states. The ISDU's memory states wait on `R`. The block replaces the external 1Mx16 SRAM and tristate path on boards and benches that lack the chip, and sits beside Mem2IO on the memory side of MAR/MDR.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width of the internal array (depth 2^ADDR_W x 16).
- `WAIT_STATES`, 2: cycles between request acceptance and `R`; legal range 0..15.

Ports:
- `Clk`  in  1  system clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `CE`  in  1  chip enable, active low.
- `OE`  in  1  output (read) enable, active low.
- `WE`  in  1  write enable, active low.
- `UB`  in  1  upper-byte lane enable, active low; applies to writes only.
- `LB`  in  1  lower-byte lane enable, active low; applies to writes only.
- `ADDR`  in  20  word address.
- `Data_from_CPU`  in  16  write data.
- `Data_to_CPU`  out  16  read data.
- `R`  out  1  ready; single-cycle pulse on access completion.

## Operation
- Request: `CE`=0 and (`OE`=0 or `WE`=0). If both `OE`=0 and `WE`=0, the request is a write.
- FSM states: IDLE, WAIT, ACK, HOLD.
  - IDLE: when a request is present, capture ADDR, Data_from_CPU, UB, LB and the read/write kind, then go to WAIT and load the counter with WAIT_STATES. If WAIT_STATES=0, go directly to ACK.
  - WAIT: decrement the counter each cycle. Go to ACK when the counter reaches 1. If the request drops (CE=1, or OE=1 and WE=1), abort to IDLE: no write, no `R`, `Data_to_CPU` unchanged.
  - ACK: `R`=1 for exactly this cycle.
    - Read: `Data_to_CPU` shows the word at the captured address during ACK and holds it until the next read's ACK.
    - Write: the array updates on the edge that ends ACK, enabled lanes only (UB=0 writes [15:8], LB=0 writes [7:0]). With both lanes disabled, nothing is written but `R` still pulses.
    - Next state is HOLD.
  - HOLD: stay until the request drops, then go to IDLE. A held request is never serviced twice.
- Out-of-range: a captured address with any bit of ADDR[19:ADDR_W] set reads 16'h0000 and drops writes. `R` still pulses.
- Captured values are used for the whole access; ADDR or data changes after acceptance are ignored.

## Timing
- Reset values: state=IDLE, `R`=0, `Data_to_CPU`=16'h0000, counter=0. The array contents are not cleared.
- Reset mid-access wins over everything: no write, no `R`, and the FSM is in IDLE on the next cycle.
- Latency: with the request first seen in IDLE in cycle T, `R`=1 in cycle T+1+WAIT_STATES.
- Back-to-back: the request must be low for at least one cycle in HOLD→IDLE. The earliest next acceptance is the cycle after HOLD exits.
- Writes are visible to a read accepted in any later cycle; there is no read-during-write hazard.
- `R` and `Data_to_CPU` are registered outputs; they have no combinational path from the inputs.

## Structure
- Package `sram_pkg` holds:
  - `sram_state_t` enum {IDLE, WAIT, ACK, HOLD}.
  - `DATA_W`=16 and `BUS_ADDR_W`=20.
  - The `OUT_OF_RANGE_DATA`=16'h0000 constant.
- Sub-module `spram_bytewise` is a single-port 2^ADDR_W x 16 array with per-byte write enables and a registered read. The FSM issues the array read on the last WAIT cycle, or in IDLE when WAIT_STATES=0, so the data lands in ACK.
- The top level contains the FSM, wait counter, capture registers and range check.

## Test plan
- Reset, then WAIT_STATES=2, write 16'hBEEF to 0x0010 with UB=LB=0, then read 0x0010 → `R` in cycle T+3 for each access; the read returns 16'hBEEF.
- Byte lanes: write 16'h1234 to 0x0020, then write 16'hAB00 with UB=0, LB=1, then read → 16'hAB34.
- Abort: start a write of 16'h5555 to 0x0030 and raise CE in the first WAIT cycle → `R` never asserts; a later read of 0x0030 returns its prior value.
- Out-of-range: with ADDR_W=10, write to 0x00400, then read 0x00400 → `R` pulses both times; the read returns 16'h0000 and 0x00000 is unchanged.
- WAIT_STATES=0 with request held for 5 cycles → exactly one `R` pulse, in cycle T+1; no second pulse until CE goes high and then low again.
- Assert Reset during WAIT of a write to 0x0040 → `R`=0 and state=IDLE after the edge; 0x0040 is unwritten.
